// File: rtl/alu_result_fifo_pkg.sv
// alu_result_pkg: shared ALU result record type and width for the result FIFO.
//   alu_result_t : packed {alu[3:0], carry, zero}, RESULT_W bits
package alu_result_pkg;
   localparam int RESULT_W = 6;
   typedef struct packed {
      logic [3:0] alu;
      logic       carry;
      logic       zero;
   } alu_result_t;
endpackage

// File: rtl/alu_result_fifo_mem.sv
// alu_result_fifo_mem: DEPTH x RESULT_W register array, one write port, one combinational read port.
//   clk         : write clock
//   we/waddr/wdata : write port
//   raddr/rdata : asynchronous read port
module alu_result_fifo_mem
   import alu_result_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  alu_result_t              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output alu_result_t              rdata
);
   alu_result_t mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular FIFO buffering ALU results for a valid/ready consumer.
//   in_valid/in_alu/in_carry/in_zero : result from the ALU (dropped when full and not popping)
//   out_ready                       : consumer takes the head entry
//   clr_overflow                    : clears overflow and drop_cnt
//   out_valid/out_alu/out_carry/out_zero : head entry, zero when empty
//   count/full/empty                : occupancy
//   overflow/drop_cnt               : sticky drop flag and saturating drop counter
module alu_result_fifo
   import alu_result_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [3:0]             in_alu,
   input  logic                   in_carry,
   input  logic                   in_zero,
   input  logic                   out_ready,
   input  logic                   clr_overflow,
   output logic                   out_valid,
   output logic [3:0]             out_alu,
   output logic                   out_carry,
   output logic                   out_zero,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, push, drop;
   alu_result_t   wdata, head;
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign out_valid = !empty;
   assign pop       = !empty && out_ready;
   // a pop frees a slot in the same cycle, so a full FIFO still accepts
   assign push      = in_valid && (!full || pop);
   assign drop      = in_valid && full && !pop;
   assign wdata     = '{alu: in_alu, carry: in_carry, zero: in_zero};
   assign {out_alu, out_carry, out_zero} = empty ? '0 : head;
   alu_result_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push && !reset),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (head)
   );
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         // a drop in the same cycle as a clear wins and counts from one
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_overflow ? DROP_W'(1) : drop_cnt + DROP_W'(drop_cnt != '1);
         end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: table vectors, directed corner sequences and a queue-based random reference check.
module tb_alu_result_fifo;
   localparam int DEPTH = 8;
   localparam int DROP_W = 8;
   logic clk = 0, reset, in_valid, in_carry, in_zero, out_ready, clr_overflow;
   logic [3:0] in_alu;
   logic out_valid, out_carry, out_zero, full, empty, overflow;
   logic [3:0] out_alu;
   logic [3:0] count;
   logic [7:0] drop_cnt;
   int n_chk = 0, n_fail = 0;
   logic [5:0] q [$];
   logic m_ov;
   int m_drop;

   alu_result_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu(in_alu), .in_carry(in_carry),
      .in_zero(in_zero), .out_ready(out_ready), .clr_overflow(clr_overflow),
      .out_valid(out_valid), .out_alu(out_alu), .out_carry(out_carry), .out_zero(out_zero),
      .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compares DUT against the queue model, then applies one clock and advances the model
   task automatic cycle(input logic v, input logic [5:0] d, input logic rdy, input logic clr, input logic rst);
      logic p, dr;
      in_valid = v; {in_alu, in_carry, in_zero} = d; out_ready = rdy; clr_overflow = clr; reset = rst;
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("head", {out_alu, out_carry, out_zero}, q.size() != 0 ? q[0] : 6'd0);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("overflow", overflow, m_ov);
      chk("drop_cnt", drop_cnt, m_drop);
      if (rst) begin
         q.delete(); m_ov = 0; m_drop = 0;
      end else begin
         p  = q.size() > 0 && rdy;
         dr = v && q.size() == DEPTH && !p;
         if (p) void'(q.pop_front());
         if (v && !dr) q.push_back(d);
         if (dr) begin
            m_ov = 1;
            m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
         end else if (clr) begin
            m_ov = 0; m_drop = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic v; logic [5:0] d; logic rdy; logic clr; logic rst;
      logic ev; logic [5:0] eh; logic [3:0] ec; logic eov; logic [7:0] ed;
   } vec_t;
   vec_t tbl [10];

   initial begin
      logic [5:0] last;
      int idx;
      tbl = '{
         '{0, 6'h00, 0, 0, 1, 0, 6'h00, 0, 0, 0},
         '{1, 6'h14, 0, 0, 0, 1, 6'h14, 1, 0, 0},
         '{1, 6'h01, 0, 0, 0, 1, 6'h14, 2, 0, 0},
         '{1, 6'h3E, 0, 0, 0, 1, 6'h14, 3, 0, 0},
         '{0, 6'h00, 1, 0, 0, 1, 6'h01, 2, 0, 0},
         '{0, 6'h00, 1, 0, 0, 1, 6'h3E, 1, 0, 0},
         '{0, 6'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0},
         '{0, 6'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0},
         '{1, 6'h0C, 1, 0, 0, 1, 6'h0C, 1, 0, 0},
         '{0, 6'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0}
      };
      m_ov = 0; m_drop = 0;
      reset = 1; in_valid = 0; {in_alu, in_carry, in_zero} = 0; out_ready = 0; clr_overflow = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_head", i), {out_alu, out_carry, out_zero}, tbl[i].eh);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
         chk($sformatf("tbl%0d_ovf", i), {overflow, drop_cnt}, {tbl[i].eov, tbl[i].ed});
      end
      // fill, then overflow by one
      for (int i = 0; i < 8; i++) cycle(1, {4'(i + 1), 2'(i)}, 0, 0, 0);
      cycle(1, {4'hA, 2'b00}, 0, 0, 0);
      chk("drop_full", {full, count}, {1'b1, 4'd8});
      chk("drop_flags", {overflow, drop_cnt}, {1'b1, 8'd1});
      chk("drop_keep_head", {out_alu, out_carry, out_zero}, {4'd1, 2'd0});
      cycle(1, {4'hB, 2'b00}, 0, 1, 0);
      chk("drop_wins_clr", {overflow, drop_cnt}, {1'b1, 8'd1});
      cycle(0, 0, 0, 1, 0);
      chk("clr", {overflow, drop_cnt}, {1'b0, 8'd0});
      // full with simultaneous push and pop
      cycle(1, {4'hC, 2'b11}, 1, 0, 0);
      chk("full_pushpop", {count, overflow}, {4'd8, 1'b0});
      for (int i = 0; i < 8; i++) begin
         last = {out_alu, out_carry, out_zero};
         cycle(0, 0, 1, 0, 0);
      end
      chk("new_last", last, {4'hC, 2'b11});
      chk("drained", empty, 1'b1);
      // drop counter saturation
      for (int i = 0; i < 8; i++) cycle(1, 6'($urandom), 0, 0, 0);
      for (int i = 0; i < 260; i++) cycle(1, 6'($urandom), 0, 0, 0);
      chk("drop_sat", drop_cnt, 8'hFF);
      // reset mid-operation with count=5, push during reset ignored
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      chk("pre_rst", {count, overflow}, {4'd5, 1'b1});
      cycle(1, {4'h7, 2'b01}, 1, 1, 1);
      chk("rst_mid", {count, out_valid, overflow, drop_cnt}, {4'd0, 1'b0, 1'b0, 8'd0});
      cycle(0, 0, 0, 0, 0);
      chk("rst_push_ignored", empty, 1'b1);
      // wrap-around: 20 values 0..F,0..3 with random ready
      idx = 0;
      for (int c = 0; c < 300 && idx < 20; c++) begin
         logic v, r, acc;
         v = 1'($urandom);
         r = 1'($urandom);
         acc = q.size() < DEPTH || (q.size() > 0 && r);
         cycle(v, {4'(idx % 16), 2'($urandom)}, r, 0, 0);
         if (v && acc) idx++;
         chk("count_max", count <= 4'd8, 1'b1);
      end
      chk("wrap_done", idx, 20);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);
      // fully random traffic
      for (int c = 0; c < 500; c++)
         cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
